// File: rtl/keypad_entry_unit.sv
// Keypad numeric-entry controller: turns 4x4 keypad presses into a
// signed decimal value with display digits, overflow LEDs and pause/switch modes.
module keypad_entry_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int DIGIT_CNT  = 8,
    parameter int OVF_CNT    = 2,
    parameter int RADIX_W    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     key_coord,
    input  logic                           ignore_pause,
    input  logic                           input_enable,
    output logic                           input_complete,
    output logic [DATA_WIDTH-1:0]          keypad_data,
    output logic [DIGIT_CNT*RADIX_W-1:0]   keypad_digits,
    output logic                           keypad_negative,
    output logic                           switch_enable,
    output logic                           cpu_pause,
    output logic [OVF_CNT-1:0]             overflow_leds,
    output logic                           value_saturated
);

    localparam int DIG_W   = DIGIT_CNT * RADIX_W;
    localparam int OVF_W   = OVF_CNT * RADIX_W;
    localparam int CNT_MAX = DIGIT_CNT + OVF_CNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int EXT_W   = DATA_WIDTH + 4;
    localparam logic [EXT_W-1:0] MAG_MIN = EXT_W'(1) << (DATA_WIDTH - 1);

    typedef enum logic [1:0] {BLOCK, KEYPAD, SWITCH, PAUSE} state_t;

    state_t                state, state_n, prev_st, prev_n;
    logic [DATA_WIDTH-1:0] mag, mag_n, data_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [OVF_W-1:0]      ovf, ovf_n;
    logic [DIG_W-1:0]      dig_n;
    logic [7:0]            prev_key;
    logic                  neg_n, sat_n, sw_n, pause_n, cmp_n, do_clr;
    logic                  key_ev, is_dig, is_bs, is_ent, is_pau, is_sw, is_sgn, is_clr;
    logic [3:0]            dval;
    logic [EXT_W-1:0]      cand, limit;

    // Key classification and edge detection against last cycle's coordinate
    always_comb begin
        key_ev = (key_coord != 8'h00) && (key_coord != prev_key);
        is_dig = 1'b0;
        is_bs  = 1'b0;
        is_ent = 1'b0;
        is_pau = 1'b0;
        is_sw  = 1'b0;
        is_sgn = 1'b0;
        is_clr = 1'b0;
        dval   = 4'd0;
        case (key_coord)
            8'hBE: begin is_dig = 1'b1; dval = 4'd0; end
            8'h77: begin is_dig = 1'b1; dval = 4'd1; end
            8'hB7: begin is_dig = 1'b1; dval = 4'd2; end
            8'hD7: begin is_dig = 1'b1; dval = 4'd3; end
            8'h7B: begin is_dig = 1'b1; dval = 4'd4; end
            8'hBB: begin is_dig = 1'b1; dval = 4'd5; end
            8'hDB: begin is_dig = 1'b1; dval = 4'd6; end
            8'h7D: begin is_dig = 1'b1; dval = 4'd7; end
            8'hBD: begin is_dig = 1'b1; dval = 4'd8; end
            8'hDD: begin is_dig = 1'b1; dval = 4'd9; end
            8'h7E: is_bs  = 1'b1;
            8'hDE: is_ent = 1'b1;
            8'hE7: is_pau = 1'b1;
            8'hEB: is_sw  = 1'b1;
            8'hED: is_sgn = 1'b1;
            8'hEE: is_clr = 1'b1;
            default: ;
        endcase
    end

    // Candidate magnitude and the range limit for the current sign
    always_comb begin
        cand  = EXT_W'(mag) * EXT_W'(10) + EXT_W'(dval);
        limit = keypad_negative ? MAG_MIN : MAG_MIN - EXT_W'(1);
    end

    // Next-state and datapath updates
    always_comb begin
        state_n = state;
        prev_n  = prev_st;
        mag_n   = mag;
        cnt_n   = cnt;
        ovf_n   = ovf;
        dig_n   = keypad_digits;
        neg_n   = keypad_negative;
        sat_n   = value_saturated;
        sw_n    = switch_enable;
        pause_n = cpu_pause;
        cmp_n   = 1'b0;
        do_clr  = 1'b0;
        unique case (state)
            BLOCK: begin
                if (input_enable) begin
                    state_n = KEYPAD;
                    sw_n    = 1'b0;
                    do_clr  = 1'b1;
                end else if (key_ev && is_pau) begin
                    state_n = PAUSE;
                    prev_n  = BLOCK;
                    pause_n = 1'b1;
                end
            end
            KEYPAD: begin
                if (key_ev) begin
                    if (is_dig) begin
                        if (!((dval == 4'd0 && cnt == '0) ||
                              cnt == CNT_W'(CNT_MAX))) begin
                            if (cand > limit) begin
                                sat_n = 1'b1;
                            end else begin
                                mag_n = DATA_WIDTH'(cand);
                                ovf_n = (ovf << RADIX_W) |
                                        OVF_W'(keypad_digits[DIG_W-1 -: RADIX_W]);
                                dig_n = (keypad_digits << RADIX_W) | DIG_W'(dval);
                                cnt_n = cnt + CNT_W'(1);
                                sat_n = 1'b0;
                            end
                        end
                    end else if (is_bs) begin
                        if (cnt != '0) begin
                            mag_n = mag / DATA_WIDTH'(10);
                            dig_n = (keypad_digits >> RADIX_W) |
                                    (DIG_W'(ovf[RADIX_W-1:0]) << (DIG_W - RADIX_W));
                            ovf_n = ovf >> RADIX_W;
                            cnt_n = cnt - CNT_W'(1);
                            sat_n = 1'b0;
                        end
                    end else if (is_sgn) begin
                        if (keypad_negative && EXT_W'(mag) == MAG_MIN) begin
                            sat_n = 1'b1;
                        end else begin
                            neg_n = ~keypad_negative;
                            sat_n = 1'b0;
                        end
                    end else if (is_clr) begin
                        do_clr = 1'b1;
                    end else if (is_sw) begin
                        state_n = SWITCH;
                        sw_n    = 1'b1;
                    end else if (is_ent) begin
                        cmp_n   = 1'b1;
                        cnt_n   = '0;
                        state_n = BLOCK;
                    end else if (is_pau) begin
                        state_n = PAUSE;
                        prev_n  = KEYPAD;
                        pause_n = 1'b1;
                    end
                end
            end
            SWITCH: begin
                if (key_ev) begin
                    if (is_sw) begin
                        state_n = KEYPAD;
                        sw_n    = 1'b0;
                    end else if (is_ent) begin
                        cmp_n   = 1'b1;
                        cnt_n   = '0;
                        state_n = BLOCK;
                    end else if (is_pau) begin
                        state_n = PAUSE;
                        prev_n  = SWITCH;
                        pause_n = 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (key_ev && is_pau && !ignore_pause) begin
                    state_n = prev_st;
                    pause_n = 1'b0;
                end
            end
            default: state_n = BLOCK;
        endcase
        if (do_clr) begin
            mag_n = '0;
            cnt_n = '0;
            ovf_n = '0;
            dig_n = '0;
            neg_n = 1'b0;
            sat_n = 1'b0;
        end
        data_n = neg_n ? -mag_n : mag_n;
    end

    // Overflow LEDs track how many digits sit beyond the display
    always_comb begin
        overflow_leds = '0;
        for (int k = 0; k < OVF_CNT; k++) begin
            overflow_leds[k] = (int'(cnt) >= DIGIT_CNT + k + 1);
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= BLOCK;
            prev_st         <= BLOCK;
            mag             <= '0;
            cnt             <= '0;
            ovf             <= '0;
            prev_key        <= 8'h00;
            keypad_digits   <= '0;
            keypad_negative <= 1'b0;
            value_saturated <= 1'b0;
            switch_enable   <= 1'b0;
            cpu_pause       <= 1'b0;
            input_complete  <= 1'b0;
            keypad_data     <= '0;
        end else begin
            state           <= state_n;
            prev_st         <= prev_n;
            mag             <= mag_n;
            cnt             <= cnt_n;
            ovf             <= ovf_n;
            prev_key        <= key_coord;
            keypad_digits   <= dig_n;
            keypad_negative <= neg_n;
            value_saturated <= sat_n;
            switch_enable   <= sw_n;
            cpu_pause       <= pause_n;
            input_complete  <= cmp_n;
            keypad_data     <= data_n;
        end
    end

endmodule

// File: tb/tb_keypad_entry_unit.sv
// Bench for keypad_entry_unit: a 32-bit and an 8-bit instance share the
// same key stream; expectations go through a queue checked after each step.
module tb_keypad_entry_unit;

    localparam logic [7:0] K0 = 8'hBE, K1 = 8'h77, K2 = 8'hB7, K3 = 8'hD7;
    localparam logic [7:0] K4 = 8'h7B, K5 = 8'hBB, K6 = 8'hDB, K7 = 8'h7D;
    localparam logic [7:0] K8 = 8'hBD, K9 = 8'hDD, KS = 8'h7E, KH = 8'hDE;
    localparam logic [7:0] KA = 8'hE7, KB = 8'hEB, KC = 8'hED, KD = 8'hEE;

    localparam int S_D32 = 0, S_DIG = 1, S_NEG = 2, S_SAT = 3, S_LED = 4;
    localparam int S_PAU = 5, S_SW = 6, S_CMP = 7, S_D8 = 8, S_SAT8 = 9;
    localparam int S_NEG8 = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  key_coord;
    logic        ignore_pause;
    logic        input_enable;

    logic        a_cmp, a_neg, a_sw, a_pau, a_sat;
    logic [31:0] a_data, a_dig;
    logic [1:0]  a_led;
    logic        b_cmp, b_neg, b_sw, b_pau, b_sat;
    logic [7:0]  b_data;
    logic [31:0] b_dig;
    logic [1:0]  b_led;

    keypad_entry_unit u32 (
        .clk(clk), .rst(rst), .key_coord(key_coord),
        .ignore_pause(ignore_pause), .input_enable(input_enable),
        .input_complete(a_cmp), .keypad_data(a_data),
        .keypad_digits(a_dig), .keypad_negative(a_neg),
        .switch_enable(a_sw), .cpu_pause(a_pau),
        .overflow_leds(a_led), .value_saturated(a_sat)
    );

    keypad_entry_unit #(.DATA_WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .key_coord(key_coord),
        .ignore_pause(ignore_pause), .input_enable(input_enable),
        .input_complete(b_cmp), .keypad_data(b_data),
        .keypad_digits(b_dig), .keypad_negative(b_neg),
        .switch_enable(b_sw), .cpu_pause(b_pau),
        .overflow_leds(b_led), .value_saturated(b_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [7:0]  key;
        int          sel;
        logic [31:0] val;
        string       name;
    } vec_t;

    exp_t sbq[$];
    vec_t tab[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_D32:  return a_data;
            S_DIG:  return a_dig;
            S_NEG:  return {31'b0, a_neg};
            S_SAT:  return {31'b0, a_sat};
            S_LED:  return {30'b0, a_led};
            S_PAU:  return {31'b0, a_pau};
            S_SW:   return {31'b0, a_sw};
            S_CMP:  return {31'b0, a_cmp};
            S_D8:   return {24'b0, b_data};
            S_SAT8: return {31'b0, b_sat};
            S_NEG8: return {31'b0, b_neg};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_v(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        sbq.push_back(e);
    endtask

    task automatic check_all();
        exp_t e;
        logic [31:0] act;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            act = obs(e.sel);
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", e.name, act, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] k);
        key_coord = k;
        tick();
        key_coord = 8'h00;
        tick();
    endtask

    task automatic add(input logic [7:0] k, input int sel,
                       input logic [31:0] val, input string name);
        vec_t v;
        v.key  = k;
        v.sel  = sel;
        v.val  = val;
        v.name = name;
        tab.push_back(v);
    endtask

    initial begin
        int pulses;

        // Saturation on the 8-bit instance
        add(K1, S_D8,   32'd1,   "t2_1");
        add(K2, S_D8,   32'd12,  "t2_12");
        add(K7, S_D8,   32'd127, "t2_127");
        add(K8, S_D8,   32'd127, "t2_rej_data");
        add(0,  S_SAT8, 32'd1,   "t2_rej_sat");
        add(KD, S_D8,   32'd0,   "t2_clr_data");
        add(0,  S_SAT8, 32'd0,   "t2_clr_sat");
        add(K1, S_D8,   32'd1,   "t2_1b");
        add(K2, S_D8,   32'd12,  "t2_12b");
        add(KC, S_D8,   32'hF4,  "t2_neg12");
        add(0,  S_NEG8, 32'd1,   "t2_neg_flag");
        add(K8, S_D8,   32'h80,  "t2_min");
        add(0,  S_SAT8, 32'd0,   "t2_min_sat");
        add(KC, S_SAT8, 32'd1,   "t2_sign_rej");
        add(0,  S_D8,   32'h80,  "t2_sign_rej_data");
        add(0,  S_NEG8, 32'd1,   "t2_sign_rej_neg");
        // Overflow store on the 32-bit instance
        add(KD, S_D32,  32'd0,   "t3_clr");
        add(K1, S_D32,  32'd1,   "t3_d1");
        add(K2, S_D32,  32'd12,  "t3_d2");
        add(K3, S_D32,  32'd123, "t3_d3");
        add(K4, S_D32,  32'd1234, "t3_d4");
        add(K5, S_D32,  32'd12345, "t3_d5");
        add(K6, S_D32,  32'd123456, "t3_d6");
        add(K7, S_D32,  32'd1234567, "t3_d7");
        add(K8, S_LED,  32'd0,   "t3_led8");
        add(0,  S_DIG,  32'h1234_5678, "t3_dig8");
        add(K9, S_LED,  32'd1,   "t3_led9");
        add(K0, S_LED,  32'd3,   "t3_led10");
        add(0,  S_D32,  32'd1234567890, "t3_data10");
        add(0,  S_DIG,  32'h3456_7890, "t3_dig10");
        add(K5, S_D32,  32'd1234567890, "t3_full_data");
        add(0,  S_LED,  32'd3,   "t3_full_led");
        add(KS, S_LED,  32'd1,   "t3_bs1_led");
        add(0,  S_DIG,  32'h2345_6789, "t3_bs1_dig");
        add(KS, S_LED,  32'd0,   "t3_bs2_led");
        add(0,  S_DIG,  32'h1234_5678, "t3_bs2_dig");
        add(0,  S_D32,  32'd12345678, "t3_bs2_data");

        rst          = 1'b1;
        key_coord    = 8'h00;
        ignore_pause = 1'b0;
        input_enable = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        expect_v("rst_data",  S_D32, 32'd0);
        expect_v("rst_dig",   S_DIG, 32'd0);
        expect_v("rst_neg",   S_NEG, 32'd0);
        expect_v("rst_sat",   S_SAT, 32'd0);
        expect_v("rst_led",   S_LED, 32'd0);
        expect_v("rst_pause", S_PAU, 32'd0);
        expect_v("rst_sw",    S_SW,  32'd0);
        expect_v("rst_cmp",   S_CMP, 32'd0);
        expect_v("rst_data8", S_D8,  32'd0);
        tick();
        check_all();

        // Held key acts once, Enter pulses once
        input_enable = 1'b1;
        tick();
        input_enable = 1'b0;
        key_coord    = K7;
        pulses       = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_cmp) pulses++;
        end
        key_coord = 8'h00;
        tick();
        expect_v("t1_hold_data", S_D32, 32'd7);
        expect_v("t1_hold_dig",  S_DIG, 32'd7);
        check_all();
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL t1_no_early_pulse: got %0d expected 0", pulses);
        end
        key_coord = KH;
        tick();
        expect_v("t1_pulse", S_CMP, 32'd1);
        check_all();
        key_coord = 8'h00;
        tick();
        expect_v("t1_pulse_end", S_CMP, 32'd0);
        expect_v("t1_data", S_D32, 32'd7);
        check_all();
        press(K2);
        expect_v("t1_block_data", S_D32, 32'd7);
        expect_v("t1_block_dig",  S_DIG, 32'd7);
        check_all();

        // Table-driven saturation and overflow sequences
        input_enable = 1'b1;
        tick();
        input_enable = 1'b0;
        tick();
        for (int i = 0; i < tab.size(); i++) begin
            if (tab[i].key != 8'h00) press(tab[i].key);
            expect_v(tab[i].name, tab[i].sel, tab[i].val);
            check_all();
        end

        // Leading zeros and backspace past empty
        press(KD);
        press(K0);
        press(K0);
        expect_v("t4_zero_dig", S_DIG, 32'd0);
        check_all();
        press(K5);
        expect_v("t4_dig",  S_DIG, 32'd5);
        expect_v("t4_data", S_D32, 32'd5);
        check_all();
        press(KS);
        press(KS);
        expect_v("t4_bs_data", S_D32, 32'd0);
        expect_v("t4_bs_dig",  S_DIG, 32'd0);
        expect_v("t4_bs_led",  S_LED, 32'd0);
        check_all();
        press(K3);
        expect_v("t4_after_empty", S_D32, 32'd3);
        check_all();

        // Pause with ignore_pause blocking resume
        ignore_pause = 1'b1;
        press(KA);
        expect_v("t5_pause_on", S_PAU, 32'd1);
        check_all();
        press(KA);
        expect_v("t5_pause_held", S_PAU, 32'd1);
        check_all();
        press(K4);
        expect_v("t5_pause_digit", S_D32, 32'd3);
        check_all();
        ignore_pause = 1'b0;
        press(KA);
        expect_v("t5_resume", S_PAU, 32'd0);
        expect_v("t5_dig",    S_DIG, 32'd3);
        check_all();
        press(K4);
        expect_v("t5_keypad", S_D32, 32'd34);
        check_all();

        // Switch mode, Enter from switch, enable vs pause, reset
        press(KB);
        expect_v("t6_sw_on", S_SW, 32'd1);
        check_all();
        press(K5);
        expect_v("t6_sw_ignore", S_D32, 32'd34);
        check_all();
        key_coord = KH;
        tick();
        expect_v("t6_pulse",   S_CMP, 32'd1);
        expect_v("t6_sw_hold", S_SW,  32'd1);
        check_all();
        key_coord = 8'h00;
        tick();
        expect_v("t6_pulse_end", S_CMP, 32'd0);
        expect_v("t6_data_held", S_D32, 32'd34);
        check_all();
        input_enable = 1'b1;
        key_coord    = KA;
        tick();
        input_enable = 1'b0;
        key_coord    = 8'h00;
        expect_v("t6_prio_pause", S_PAU, 32'd0);
        expect_v("t6_prio_data",  S_D32, 32'd0);
        check_all();
        tick();
        press(K6);
        press(K7);
        press(KC);
        expect_v("t6_neg_data", S_D32, 32'hFFFF_FFBD);
        expect_v("t6_neg_flag", S_NEG, 32'd1);
        check_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_v("t6_rst_data", S_D32, 32'd0);
        expect_v("t6_rst_dig",  S_DIG, 32'd0);
        expect_v("t6_rst_neg",  S_NEG, 32'd0);
        expect_v("t6_rst_sat",  S_SAT, 32'd0);
        expect_v("t6_rst_led",  S_LED, 32'd0);
        expect_v("t6_rst_pau",  S_PAU, 32'd0);
        expect_v("t6_rst_sw",   S_SW,  32'd0);
        expect_v("t6_rst_cmp",  S_CMP, 32'd0);
        check_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
